dcache_multislot: RTL and testbench
===================================

// Module: dcache_multislot
// PURPOSE
// Parametrised successor to the single-port DMA data cache. Holds NUM_SLOTS tile slots of
// DEPTH words x DATA_W bits, behind one DMA write port and one DMA read port.
// Read latency is configurable. Same-address collision policy is selectable.
// An FSM-driven slot-clear engine zeroes one whole slot without CPU or DMA help.
// Sits between the DMA engine and the tile compute units, in the Memory subsystem.
// PARAMETERS
// NUM_SLOTS    4      number of tile slots (>=2, power of 2); SLOT_W = $clog2(NUM_SLOTS)
// DEPTH        2048   words per slot (power of 2); ADDR_W = $clog2(DEPTH)
// DATA_W       18     word width in bits
// READ_LAT     1      read latency in cycles, 1..3 (extra stages are output registers)
// WRITE_FIRST  0      collision policy: 0 = read returns old data, 1 = read returns new write data
// PORTS
// clk                 in   1       single clock, rising edge
// reset               in   1       asynchronous, active-high reset
// dma_write_slot      in   SLOT_W  write slot select
// dma_write_addr      in   ADDR_W  write word address
// dma_write_we        in   1       write request; takes effect only when dma_write_ready=1
// dma_write_dat       in   DATA_W  write data
// dma_write_ready     out  1       1 = write port accepts; 0 while clear engine is busy
// dma_read_slot       in   SLOT_W  read slot select
// dma_read_addr       in   ADDR_W  read word address
// dma_read_re         in   1       read request; always accepted
// dma_read_dat        out  DATA_W  read data, valid when dma_read_complete=1
// dma_read_complete   out  1       1-cycle pulse, READ_LAT cycles after the re cycle
// clear_req           in   1       start a slot clear; sampled only in IDLE
// clear_slot          in   SLOT_W  slot to clear, captured with clear_req
// clear_busy          out  1       1 while the clear FSM is in CLEAR
// clear_done          out  1       1-cycle pulse after the last word of the slot is zeroed
// BEHAVIOUR
// - Reset values: dma_read_dat=0, dma_read_complete=0, read pipeline valid bits=0,
//   dma_write_ready=1, clear_busy=0, clear_done=0, FSM=IDLE, clear counter=0.
//   Reset does not initialise or clear storage contents.
// - Storage: NUM_SLOTS*DEPTH words. Flat index = {slot, addr}.
// - Write: when we & ready at a posedge, mem[{slot,addr}] <= dat. Writes while ready=0
//   are dropped, with no side effects. The DMA must hold the request until ready=1.
// - Read: a re cycle at edge N drives dat/complete valid after edge N+READ_LAT-1.
//   READ_LAT=1 matches legacy timing (valid just after the next edge).
// - Back-to-back reads: one read per cycle, fully pipelined. complete mirrors the re pattern.
//   dat holds its last value when complete=0.
// - Collision (write and read to the same {slot,addr} at the same edge):
//   WRITE_FIRST=0 -> read returns the pre-write value.
//   WRITE_FIRST=1 -> read returns dma_write_dat.
//   A different slot or different addr means no interaction.
// - Clear FSM:
//   IDLE: clear_req=1 -> latch clear_slot, cnt=0, go to CLEAR; ready=0 from the next cycle.
//   CLEAR: each cycle writes 0 to {cslot,cnt}, then cnt++. At cnt=DEPTH-1, write and go to DONE.
//     clear_req is ignored while in CLEAR.
//   DONE: clear_done=1 for one cycle, ready=1 again, go to IDLE.
//   A clear takes DEPTH+1 cycles from request to done pulse.
// - Reads during a clear are allowed, on any slot. Reading the slot being cleared returns
//   the current contents: 0 if that word is already cleared, else the old value.
//   The collision rule applies against clear writes as well.
// - Counter wrap: cnt is ADDR_W bits and wraps to 0 at DONE. No overflow into the slot bits.
// - Reset mid-clear: FSM returns to IDLE immediately and ready=1. The slot is left partially
//   cleared. In-flight read pipeline entries are discarded (complete=0).
// - Out-of-range slot: impossible when NUM_SLOTS is a power of 2. Enforce this in an
//   elaboration-time check, together with READ_LAT in 1..3.
// TESTING
// 1 Basic, READ_LAT=1: write slot2/addr0 = 3423; next cycle read -> dat=3423, complete=1;
//   the write cycle itself has complete=0.
// 2 Collision: mem=3423; same edge write 1337 and read same addr ->
//   WRITE_FIRST=0 gives 3423, WRITE_FIRST=1 gives 1337; a following read gives 1337.
// 3 Pipelined, READ_LAT=3: reads of addr 5,6,7 on consecutive cycles ->
//   complete high for 3 cycles starting 3 edges after the first re, with data in order.
// 4 Clear, DEPTH=16: fill slot1 with 0xAA and slot0 with 0x55; clear_req slot1 ->
//   busy 16 cycles, done pulse at cycle 17; slot1 reads 0, slot0 reads 0x55.
// 5 Blocked write: write we=1 during a clear -> ready=0 and write dropped;
//   the same write after done lands.
// 6 Reset mid-clear: assert reset at cnt=7 -> busy=0, ready=1, complete=0 immediately;
//   words 0..6 read 0 and words 7..15 keep their old values.

Source files
------------

// File: rtl/dcache_multislot.sv
// rtl/dcache_multislot.sv - multi-slot DMA data cache with pipelined reads and slot-clear engine
module dcache_multislot #(
    parameter int  NUM_SLOTS   = 4,
    parameter int  DEPTH       = 2048,
    parameter int  DATA_W      = 18,
    parameter int  READ_LAT    = 1,
    parameter int  WRITE_FIRST = 0,
    localparam int SLOT_W      = $clog2(NUM_SLOTS),
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SLOT_W-1:0] dma_write_slot,
    input  logic [ADDR_W-1:0] dma_write_addr,
    input  logic              dma_write_we,
    input  logic [DATA_W-1:0] dma_write_dat,
    output logic              dma_write_ready,
    input  logic [SLOT_W-1:0] dma_read_slot,
    input  logic [ADDR_W-1:0] dma_read_addr,
    input  logic              dma_read_re,
    output logic [DATA_W-1:0] dma_read_dat,
    output logic              dma_read_complete,
    input  logic              clear_req,
    input  logic [SLOT_W-1:0] clear_slot,
    output logic              clear_busy,
    output logic              clear_done
);

    localparam int IDX_W = SLOT_W + ADDR_W;

    // A non-power-of-2 slot count would leave unreachable {slot,addr} codes.
    if (NUM_SLOTS < 2 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0) begin : g_bad_slots
        $error("dcache_multislot: NUM_SLOTS must be a power of 2 and >= 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dcache_multislot: DEPTH must be a power of 2");
    end
    if (READ_LAT < 1 || READ_LAT > 3) begin : g_bad_lat
        $error("dcache_multislot: READ_LAT must be 1..3");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [SLOT_W-1:0]   cslot_q, cslot_d;
    logic                clr_we;

    logic [DATA_W-1:0]   mem [NUM_SLOTS*DEPTH];
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [DATA_W-1:0]   wr_dat;
    logic [IDX_W-1:0]    rd_idx;
    logic                collide;

    logic [READ_LAT-1:0] pipe_vld;
    logic [DATA_W-1:0]   pipe_dat [READ_LAT];

    // The clear engine owns the single write port while busy; DMA writes are dropped then.
    assign wr_en   = clr_we | (dma_write_we & dma_write_ready);
    assign wr_idx  = clr_we ? {cslot_q, cnt_q} : {dma_write_slot, dma_write_addr};
    assign wr_dat  = clr_we ? '0 : dma_write_dat;
    assign rd_idx  = {dma_read_slot, dma_read_addr};
    assign collide = wr_en && (wr_idx == rd_idx);

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    // Read pipeline: stage 0 is the array read, later stages are output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= dma_read_re;
            if (dma_read_re) begin
                pipe_dat[0] <= (WRITE_FIRST != 0 && collide) ? wr_dat : mem[rd_idx];
            end
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end
    end

    assign dma_read_dat      = pipe_dat[READ_LAT-1];
    assign dma_read_complete = pipe_vld[READ_LAT-1];

    // Clear FSM state, word counter and captured slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cslot_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cslot_q <= cslot_d;
        end
    end

    // Clear FSM next state and outputs; the counter wraps to 0 on its last increment.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cslot_d         = cslot_q;
        clr_we          = 1'b0;
        clear_busy      = 1'b0;
        clear_done      = 1'b0;
        dma_write_ready = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    cslot_d = clear_slot;
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear_busy      = 1'b1;
                dma_write_ready = 1'b0;
                clr_we          = 1'b1;
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                clear_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_multislot.sv
// tb/tb_dcache_multislot.sv - scoreboard bench for dcache_multislot (read-first/lat1 and write-first/lat3)
module tb_dcache_multislot;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        logic [17:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  wslot = '0;
    logic [3:0]  waddr = '0;
    logic        we = 1'b0;
    logic [17:0] wdat = '0;
    logic [1:0]  rslot = '0;
    logic [3:0]  raddr = '0;
    logic        re = 1'b0;
    logic        creq = 1'b0;
    logic [1:0]  cslot = '0;

    logic        a_ready, a_cmp, a_busy, a_done;
    logic [17:0] a_dat;
    logic        b_ready, b_cmp, b_busy, b_done;
    logic [17:0] b_dat;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   edge_count = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    dcache_multislot #(.NUM_SLOTS(4), .DEPTH(16), .DATA_W(18), .READ_LAT(LAT_A), .WRITE_FIRST(0)) dut_a (
        .clk(clk), .reset(reset),
        .dma_write_slot(wslot), .dma_write_addr(waddr), .dma_write_we(we), .dma_write_dat(wdat),
        .dma_write_ready(a_ready),
        .dma_read_slot(rslot), .dma_read_addr(raddr), .dma_read_re(re),
        .dma_read_dat(a_dat), .dma_read_complete(a_cmp),
        .clear_req(creq), .clear_slot(cslot), .clear_busy(a_busy), .clear_done(a_done)
    );

    dcache_multislot #(.NUM_SLOTS(4), .DEPTH(16), .DATA_W(18), .READ_LAT(LAT_B), .WRITE_FIRST(1)) dut_b (
        .clk(clk), .reset(reset),
        .dma_write_slot(wslot), .dma_write_addr(waddr), .dma_write_we(we), .dma_write_dat(wdat),
        .dma_write_ready(b_ready),
        .dma_read_slot(rslot), .dma_read_addr(raddr), .dma_read_re(re),
        .dma_read_dat(b_dat), .dma_read_complete(b_cmp),
        .clear_req(creq), .clear_slot(cslot), .clear_busy(b_busy), .clear_done(b_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_count++;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", nm, act, exp, edge_count);
        end
    endtask

    // Monitor for the read-first, latency-1 instance.
    always @(negedge clk) begin
        if (!reset && a_cmp) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_complete", 1, 0);
            end else begin
                ea = qa.pop_front();
                chk("a_rd_dat", int'(a_dat), int'(ea.d));
                chk("a_rd_lat", edge_count, ea.due);
            end
        end
    end

    // Monitor for the write-first, latency-3 instance.
    always @(negedge clk) begin
        if (!reset && b_cmp) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_complete", 1, 0);
            end else begin
                eb = qb.pop_front();
                chk("b_rd_dat", int'(b_dat), int'(eb.d));
                chk("b_rd_lat", edge_count, eb.due);
            end
        end
    end

    task automatic step(input bit w, input int ws, input int wa, input int wd,
                        input bit r, input int rs, input int ra, input int exa, input int exb);
        exp_t e;
        we    = w;
        wslot = 2'(ws);
        waddr = 4'(wa);
        wdat  = 18'(wd);
        re    = r;
        rslot = 2'(rs);
        raddr = 4'(ra);
        if (r) begin
            e.d = 18'(exa); e.due = edge_count + LAT_A; qa.push_back(e);
            e.d = 18'(exb); e.due = edge_count + LAT_B; qb.push_back(e);
        end
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int s, input int a, input int d);
        step(1, s, a, d, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int s, input int a, input int e);
        step(0, 0, 0, 0, 1, s, a, e, e);
    endtask

    task automatic drain();
        for (int i = 0; i < LAT_B + 2; i++) idle();
    endtask

    int nbusy, ndone, done_at, busy_ready;

    initial begin
        // Reset state
        #1;
        chk("rst_a_ready", a_ready, 1);   chk("rst_b_ready", b_ready, 1);
        chk("rst_a_busy", a_busy, 0);     chk("rst_a_done", a_done, 0);
        chk("rst_a_cmp", a_cmp, 0);       chk("rst_b_cmp", b_cmp, 0);
        chk("rst_a_dat", int'(a_dat), 0); chk("rst_b_dat", int'(b_dat), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic write then read
        wr(2, 0, 3423);
        rd(2, 0, 3423);
        drain();

        // Same-address collision, then a plain read of the new value
        step(1, 2, 0, 1337, 1, 2, 0, 3423, 1337);
        rd(2, 0, 1337);
        drain();

        // Pipelined back-to-back reads, plus a non-colliding write/read pair
        wr(3, 5, 100); wr(3, 6, 200); wr(3, 7, 300);
        rd(3, 5, 100); rd(3, 6, 200); rd(3, 7, 300);
        step(1, 3, 5, 111, 1, 3, 6, 200, 200);
        step(1, 1, 7, 999, 1, 3, 7, 300, 300);
        rd(3, 5, 111);
        drain();

        // Slot clear with blocked write, ignored second request and reads during the clear
        for (int a = 0; a < 16; a++) wr(1, a, 'hAA);
        for (int a = 0; a < 16; a++) wr(0, a, 'h55);
        creq = 1'b1; cslot = 2'd1;
        @(negedge clk);
        creq = 1'b0;
        nbusy = 0; ndone = 0; done_at = 0; busy_ready = 0;
        for (int i = 1; i <= 22; i++) begin
            if (a_busy) nbusy++;
            if (a_done) begin ndone++; done_at = i; end
            if (a_busy && a_ready) busy_ready++;
            if (i == 5) chk("clear_b_ready", b_ready, 0);
            creq  = (i == 10);
            cslot = (i == 10) ? 2'd0 : 2'd1;
            case (i)
                5:       wr(1, 3, 'h123);
                6:       rd(0, 2, 'h55);
                7:       rd(1, 15, 'hAA);
                9:       step(0, 0, 0, 0, 1, 1, 8, 'hAA, 0);
                default: idle();
            endcase
        end
        creq = 1'b0;
        chk("clear_busy_cycles", nbusy, 16);
        chk("clear_done_count", ndone, 1);
        chk("clear_done_cycle", done_at, 17);
        chk("clear_ready_while_busy", busy_ready, 0);
        chk("post_clear_a_ready", a_ready, 1);
        for (int a = 0; a < 16; a++) rd(1, a, 0);
        for (int a = 0; a < 16; a += 5) rd(0, a, 'h55);
        wr(1, 3, 'h123);
        rd(1, 3, 'h123);
        drain();

        // Reset in the middle of a clear, with a read still in flight
        for (int a = 0; a < 16; a++) wr(1, a, 'h100 + a);
        creq = 1'b1; cslot = 2'd1;
        @(negedge clk);
        creq = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) rd(0, 0, 'h55);
            else idle();
        end
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_a_busy", a_busy, 0);  chk("midrst_b_busy", b_busy, 0);
        chk("midrst_a_ready", a_ready, 1); chk("midrst_b_ready", b_ready, 1);
        chk("midrst_a_cmp", a_cmp, 0);    chk("midrst_b_cmp", b_cmp, 0);
        qa.delete();
        qb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 16; a++) rd(1, a, (a < 7) ? 0 : 'h100 + a);
        drain();
        chk("a_pending_reads", qa.size(), 0);
        chk("b_pending_reads", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=%0d required=finish", edge_count);
        $fatal(1, "timeout");
    end

endmodule
